mv_result_drain: RTL

MV_RESULT_DRAIN -- requirements
Module: mv_result_drain

---
 rtl/mv_result_drain.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/mv_result_drain.sv
// mv_result_drain: kicks the matrix-vector multiplier through a start/done status-word handshake,
// then streams length_M y-words out of BRAM. Define MVD_TIMEOUT_EN to add the START/CLEAR watchdog.
module mv_result_drain #(
  parameter int addr_y_size    = 12,
  parameter int length_M       = 128,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   job_done,
  output logic                   err,
  output logic [31:0]            ps_control,
  input  logic [31:0]            pl_status,
  output logic [addr_y_size-1:0] bram_addr_y,
  input  logic [31:0]            bram_rddata_y,
  output logic [31:0]            bram_wrdata_y,
  output logic [3:0]             bram_we_y,
  output logic                   bram_sel,
  output logic [31:0]            m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last
);

  // state | meaning
  // IDLE  | waiting for start
  // START | ps_control[0] high until the multiplier reports done
  // CLEAR | start dropped, waiting for done to clear
  // DRAIN | reading y words from BRAM into the result stream
  // DONE  | one-cycle job_done pulse
  typedef enum logic [2:0] {IDLE, START, CLEAR, DRAIN, DONE} state_t;

  localparam int            IW   = $clog2(length_M + 1);
  localparam logic [IW-1:0] LEN  = IW'(length_M);
  localparam logic [IW-1:0] LAST = IW'(length_M - 1);

  state_t        state_q, state_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [IW-1:0] out_idx_q, out_idx_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    count_q, count_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [31:0]   fifo_mem_q [2];
  logic [31:0]   fifo_mem_d [2];
  logic          issue;
  logic          push;
  logic          pop;
  logic          unused_status;

`ifdef MVD_TIMEOUT_EN
  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    rd_idx_d   = rd_idx_q;
    out_idx_d  = out_idx_q;
    inflight_d = 1'b0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_mem_d = fifo_mem_q;
    issue      = 1'b0;
    push       = inflight_q;
    pop        = m_valid & m_ready;
`ifdef MVD_TIMEOUT_EN
    tmr_d      = tmr_q;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
`ifdef MVD_TIMEOUT_EN
          tmr_d   = TMR_LOAD;
          err_d   = 1'b0;
`endif
        end
      end
      START: if (pl_status[0]) state_d = CLEAR;
      CLEAR: if (!pl_status[0]) state_d = DRAIN;
      DRAIN: begin
        // Buffered plus in-flight never exceeds two, so a returning read always has a slot.
        issue = (rd_idx_q < LEN) &&
                ((count_q == 2'd0) || ((count_q == 2'd1) && !inflight_q));
        if (pop && m_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MVD_TIMEOUT_EN
    if (((state_q == START) || (state_q == CLEAR)) && (state_d == state_q)) begin
      if (tmr_q == '0) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        tmr_d = tmr_q - TW'(1);
      end
    end
`endif

    if (issue) begin
      rd_idx_d   = rd_idx_q + IW'(1);
      inflight_d = 1'b1;
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q] = bram_rddata_y;
      wr_ptr_d             = ~wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d  = ~rd_ptr_q;
      out_idx_d = out_idx_q + IW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    if (state_q != DRAIN) begin
      rd_idx_d   = '0;
      out_idx_d  = '0;
      inflight_d = 1'b0;
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      rd_idx_q   <= '0;
      out_idx_q  <= '0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_mem_q <= '{default: '0};
`ifdef MVD_TIMEOUT_EN
      tmr_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      out_idx_q  <= out_idx_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_mem_q <= fifo_mem_d;
`ifdef MVD_TIMEOUT_EN
      tmr_q      <= tmr_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef MVD_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy          = (state_q != IDLE);
  assign job_done      = (state_q == DONE);
  assign ps_control    = {31'd0, (state_q == START)};
  assign bram_sel      = (state_q == DRAIN) || (state_q == DONE);
  assign bram_addr_y   = (state_q == DRAIN) ? addr_y_size'({rd_idx_q, 2'b00}) : '0;
  assign bram_wrdata_y = 32'd0;
  assign bram_we_y     = 4'd0;
  assign m_valid       = (count_q != 2'd0);
  assign m_data        = m_valid ? fifo_mem_q[rd_ptr_q] : 32'd0;
  assign m_last        = m_valid && (out_idx_q == LAST);
  assign unused_status = ^pl_status[31:1];

endmodule
